// File: rtl/clock_rate_scheduler_if.sv
// Control/status bundle of the clock rate scheduler: run/burst requests,
// config handshake and the divided-clock status outputs.
interface clock_rate_scheduler_if;
  localparam int unsigned LIMIT_W = 32;
  localparam int unsigned BURST_W = 16;

  logic               run;
  logic               burst_start;
  logic [BURST_W-1:0] burst_count;
  logic               cfg_valid;
  logic [LIMIT_W-1:0] cfg_limit;
  logic               cfg_ready;
  logic               clkout;
  logic               tick;
  logic               busy;
  logic [LIMIT_W-1:0] cur_limit;

  modport master (
    output run, burst_start, burst_count, cfg_valid, cfg_limit,
    input  cfg_ready, clkout, tick, busy, cur_limit
  );

  modport slave (
    input  run, burst_start, burst_count, cfg_valid, cfg_limit,
    output cfg_ready, clkout, tick, busy, cur_limit
  );
endinterface

// File: rtl/clock_rate_scheduler.sv
// Programmable half-period divider with glitch-free rate changes at period
// boundaries and free-run / graceful-stop / N-pulse burst sequencing.
module clock_rate_scheduler #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned DEFAULT_HZ = 1000
) (
  input logic                   clkin,
  input logic                   rst_n,
  clock_rate_scheduler_if.slave bus
);
  localparam int unsigned LIMIT_W = 32;
  localparam int unsigned BURST_W = 16;
  localparam int unsigned CMP_W   = LIMIT_W + 1;
  localparam logic [LIMIT_W-1:0] RESET_LIMIT = LIMIT_W'(CLK_HZ / 2 / DEFAULT_HZ);

  typedef enum logic [1:0] {IDLE, FREE, STOPPING, BURST} state_t;

  state_t             state;
  logic [LIMIT_W-1:0] cnt;
  logic [LIMIT_W-1:0] cur_limit_q;
  logic [LIMIT_W-1:0] pend;
  logic [BURST_W-1:0] rem;
  logic               clkout_q;
  logic               tick_q;
  logic               busy_q;
  logic               cfg_ready_q;
  logic               wrap_c;
  logic               counting_c;
  logic               rise_c;
  logic               fall_c;

  // Widened compare so cnt+1 cannot wrap when cur_limit is at its maximum.
  assign wrap_c     = (CMP_W'(cnt) + CMP_W'(1)) >= CMP_W'(cur_limit_q);
  // FREE with run dropped during the low phase stops at once instead of counting.
  assign counting_c = (state == STOPPING) || (state == BURST) ||
                      ((state == FREE) && (bus.run || clkout_q));
  assign rise_c     = counting_c && wrap_c && !clkout_q;
  assign fall_c     = counting_c && wrap_c && clkout_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_limit_q <= RESET_LIMIT;
      pend        <= '0;
      rem         <= '0;
      clkout_q    <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      tick_q <= rise_c;

      // A low cfg_ready doubles as the "config pending" flag.
      if (bus.cfg_valid && cfg_ready_q) begin
        pend        <= (bus.cfg_limit == '0) ? LIMIT_W'(1) : bus.cfg_limit;
        cfg_ready_q <= 1'b0;
      end

      if (counting_c) begin
        if (wrap_c) begin
          cnt      <= '0;
          clkout_q <= ~clkout_q;
        end else begin
          cnt <= cnt + LIMIT_W'(1);
        end
      end

      // Rate changes land only on a falling toggle, i.e. a full-period boundary.
      if (fall_c && !cfg_ready_q) begin
        cur_limit_q <= pend;
        cfg_ready_q <= 1'b1;
      end

      if (rise_c && (state == BURST)) rem <= rem - BURST_W'(1);

      unique case (state)
        IDLE: begin
          cnt      <= '0;
          clkout_q <= 1'b0;
          if (!cfg_ready_q) begin
            cur_limit_q <= pend;
            cfg_ready_q <= 1'b1;
          end
          if (bus.run) begin
            state  <= FREE;
            busy_q <= 1'b1;
          end else if (bus.burst_start && (bus.burst_count != '0)) begin
            state  <= BURST;
            busy_q <= 1'b1;
            rem    <= bus.burst_count;
          end
        end
        FREE: begin
          if (!bus.run) begin
            if (!clkout_q || fall_c) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              cnt    <= '0;
            end else begin
              state <= STOPPING;
            end
          end
        end
        STOPPING: begin
          if (fall_c) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        BURST: begin
          if (fall_c && (rem == '0)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.clkout    = clkout_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cur_limit = cur_limit_q;
endmodule

// File: tb/tb_clock_rate_scheduler.sv
// Bench for clock_rate_scheduler: vector table, directed corner sequences and
// random stimulus compared every cycle against a phase-countdown reference model.
module tb_clock_rate_scheduler;
  localparam logic [31:0] RST_LIMIT = 32'd25000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STOP  = 2;
  localparam int M_BURST = 3;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        bstart;
    logic [15:0] bcount;
    logic        cv;
    logic [31:0] cl;
    logic        co;
    logic        tk;
    logic        bs;
    logic        rd;
    logic [31:0] lim;
  } vec_t;

  logic clkin = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  clock_rate_scheduler_if bus();

  clock_rate_scheduler #(.CLK_HZ(50000000), .DEFAULT_HZ(1000)) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clkin = ~clkin;

  // Reference model: time left in the current phase and rises left in a burst.
  int          m_mode   = M_IDLE;
  logic        m_level  = 1'b0;
  logic        m_tick   = 1'b0;
  logic        m_ready  = 1'b1;
  logic [31:0] m_limit  = RST_LIMIT;
  logic [31:0] m_pend   = 32'd0;
  longint      m_left   = 0;
  int          m_pulses = 0;

  task automatic model_step();
    logic had_pend;
    logic take;
    logic fell;
    had_pend = !m_ready;
    take     = bus.cfg_valid && m_ready;
    fell     = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_level = 1'b0; m_tick = 1'b0; m_ready = 1'b1;
      m_limit = RST_LIMIT; m_left = 0; m_pulses = 0;
    end else begin
      m_tick = 1'b0;
      if (m_mode == M_IDLE) begin
        if (had_pend) begin m_limit = m_pend; m_ready = 1'b1; end
        if (bus.run) begin
          m_mode = M_RUN; m_left = longint'(m_limit);
        end else if (bus.burst_start && bus.burst_count != 16'd0) begin
          m_mode = M_BURST; m_left = longint'(m_limit); m_pulses = int'(bus.burst_count);
        end
      end else if (m_mode == M_RUN && !bus.run && !m_level) begin
        m_mode = M_IDLE;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_level = !m_level;
          if (m_level) begin
            m_tick = 1'b1;
            if (m_mode == M_BURST) m_pulses = m_pulses - 1;
          end else begin
            fell = 1'b1;
            if (had_pend) begin m_limit = m_pend; m_ready = 1'b1; end
          end
          m_left = longint'(m_limit);
        end
        if (m_mode == M_RUN && !bus.run) m_mode = fell ? M_IDLE : M_STOP;
        else if (m_mode == M_STOP && fell) m_mode = M_IDLE;
        else if (m_mode == M_BURST && fell && m_pulses == 0) m_mode = M_IDLE;
      end
      if (take) begin
        m_pend  = (bus.cfg_limit == 32'd0) ? 32'd1 : bus.cfg_limit;
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic check(string name, logic co, logic tk, logic bs, logic rd, logic [31:0] lim);
    vectors++;
    if (bus.clkout !== co || bus.tick !== tk || bus.busy !== bs ||
        bus.cfg_ready !== rd || bus.cur_limit !== lim) begin
      miscompares++;
      $display("FAIL %s @%0t: got clkout=%b tick=%b busy=%b cfg_ready=%b cur_limit=%0d, want %b %b %b %b %0d",
               name, $time, bus.clkout, bus.tick, bus.busy, bus.cfg_ready, bus.cur_limit,
               co, tk, bs, rd, lim);
    end
  endtask

  task automatic check_val(string name, longint got, longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge clkin);
    model_step();
    #1;
    check("model", m_level, m_tick, m_mode != M_IDLE, m_ready, m_limit);
  endtask

  task automatic drive(logic r, logic run, logic bs, logic [15:0] bc, logic cv, logic [31:0] cl);
    rst_n           = r;
    bus.run         = run;
    bus.burst_start = bs;
    bus.burst_count = bc;
    bus.cfg_valid   = cv;
    bus.cfg_limit   = cl;
  endtask

  function automatic vec_t mk(logic r, logic run, logic bst, logic [15:0] bc, logic cv,
                              logic [31:0] cl, logic co, logic tk, logic bs, logic rd,
                              logic [31:0] lim);
    vec_t v;
    v.rst_n = r; v.run = run; v.bstart = bst; v.bcount = bc; v.cv = cv; v.cl = cl;
    v.co = co; v.tk = tk; v.bs = bs; v.rd = rd; v.lim = lim;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int n;
    int rises;
    int high_cyc;
    logic run_r;

    // Reset, config 4 in IDLE, run; then config 0 (stored as 1) applied at a fall.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST_LIMIT));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4, 0, 0, 0, 0, RST_LIMIT));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 4));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 4));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].run, tbl[i].bstart, tbl[i].bcount, tbl[i].cv, tbl[i].cl);
      cycle();
      check($sformatf("table[%0d]", i), tbl[i].co, tbl[i].tk, tbl[i].bs, tbl[i].rd, tbl[i].lim);
    end

    // Default rate after reset: rise 25000 edges after run is sampled.
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 0, 0, 0, 0);
    n = 0;
    do begin cycle(); n++; end while (bus.clkout !== 1'b1 && n < 30000);
    check_val("t1_first_rise", n, 25001);
    check_val("t1_tick_at_rise", longint'(bus.tick), 1);
    check_val("t1_cur_limit", longint'(bus.cur_limit), 25000);
    n = 0;
    do begin cycle(); n++; end while (bus.clkout !== 1'b0 && n < 30000);
    check_val("t1_high_phase", n, 25000);
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    check_val("t1_stop_in_low", longint'(bus.busy), 0);

    // Burst of 3 at limit 3 with run asserted mid-burst.
    drive(1, 0, 0, 0, 1, 3);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 1, 3, 0, 0);
    cycle();
    rises = 0; high_cyc = 0; n = 0;
    do begin
      drive(1, n >= 5, 0, 0, 0, 0);
      cycle();
      n++;
      if (bus.tick === 1'b1) rises++;
      if (bus.clkout === 1'b1) high_cyc++;
    end while (bus.busy === 1'b1 && n < 200);
    check_val("t5_burst_ended", longint'(n < 200), 1);
    check_val("t5_rises", rises, 3);
    check_val("t5_high_cycles", high_cyc, 9);
    check_val("t5_clkout_low", longint'(bus.clkout), 0);
    drive(1, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    check_val("t5_zero_burst_idle", longint'(bus.busy), 0);

    // Reset mid-burst with a config pending.
    drive(1, 0, 1, 5, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    drive(1, 0, 0, 0, 1, 7);
    cycle();
    check_val("t6_pending", longint'(bus.cfg_ready), 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("t6_reset", 1'b0, 1'b0, 1'b0, 1'b1, RST_LIMIT);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    check("t6_pending_lost", 1'b0, 1'b0, 1'b0, 1'b1, RST_LIMIT);

    // Random traffic against the model.
    drive(1, 0, 0, 0, 1, 3);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    run_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run_r = ~run_r;
      drive(1, run_r, $urandom_range(0, 19) == 0, 16'($urandom_range(0, 4)),
            $urandom_range(0, 7) == 0, 32'($urandom_range(0, 6)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
